// File: rtl/cmul_share_arbiter.sv
// cmul_share_arbiter: one signed multiplier shared among NUM_REQ requesters.
// Each accepted request runs the 3-multiply Gauss complex product
// (k1 = br*(ar+ai), k2 = ar*(bi-br), k3 = ai*(br+bi)) over states M1..M3
// and presents real = k1-k3, imag = k1+k2 in OUT until the consumer takes it.
// Optional build macro: CMUL_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest valid index wins); default is round-robin.
module cmul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a_real,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a_imag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b_real,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b_imag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ID_W-1:0]             out_id,
    output logic signed [2*DATA_W:0]    out_real,
    output logic signed [2*DATA_W:0]    out_imag,
    output logic                        busy
);

    localparam int SW = DATA_W + 1;     // sum/difference width
    localparam int PW = 2 * DATA_W + 1; // product/result width

    typedef enum logic [2:0] {IDLE, M1, M2, M3, OUT} state_t;

    state_t state, state_nx;

    logic signed [DATA_W-1:0] ar, ai, br, bi;
    logic [ID_W-1:0]          id_q;
    logic signed [PW-1:0]     k1, k2;

    logic [NUM_REQ-1:0]       gnt_oh;
    logic [ID_W-1:0]          gnt_idx;
    logic                     gnt_any;

`ifndef CMUL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]          rr_ptr;
`endif

    // Grant selection; walking the candidates from last to first lets the
    // highest-priority hit overwrite the others.
    always_comb begin
        int idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
`ifdef CMUL_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_oh      = '0;
                gnt_oh[i]   = 1'b1;
                gnt_idx     = ID_W'(i);
                gnt_any     = 1'b1;
            end
        end
`else
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                gnt_oh      = '0;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = ID_W'(idx);
                gnt_any     = 1'b1;
            end
        end
`endif
    end

    assign req_ready = (state == IDLE) ? gnt_oh : '0;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // Pre-adders feeding the shared multiplier.
    logic signed [SW-1:0] s_arai, d_bibr, s_brbi;
    assign s_arai = ar + ai;
    assign d_bibr = bi - br;
    assign s_brbi = br + bi;

    // Operand steering: the one multiplier sees a different pair per state.
    logic signed [DATA_W-1:0] mul_a;
    logic signed [SW-1:0]     mul_b;
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            M1: begin mul_a = br; mul_b = s_arai; end
            M2: begin mul_a = ar; mul_b = d_bibr; end
            M3: begin mul_a = ai; mul_b = s_brbi; end
            default: ;
        endcase
    end

    // The single multiplier; operands are sign-extended so the product is exact.
    logic signed [PW-1:0] mul_ax, mul_bx, prod;
    assign mul_ax = mul_a;
    assign mul_bx = mul_b;
    assign prod   = mul_ax * mul_bx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any) state_nx = M1;
            M1:      state_nx = M2;
            M2:      state_nx = M3;
            M3:      state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on accept, partial products, and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar       <= '0;
            ai       <= '0;
            br       <= '0;
            bi       <= '0;
            id_q     <= '0;
            k1       <= '0;
            k2       <= '0;
            out_id   <= '0;
            out_real <= '0;
            out_imag <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    ar   <= req_a_real[int'(gnt_idx)*DATA_W +: DATA_W];
                    ai   <= req_a_imag[int'(gnt_idx)*DATA_W +: DATA_W];
                    br   <= req_b_real[int'(gnt_idx)*DATA_W +: DATA_W];
                    bi   <= req_b_imag[int'(gnt_idx)*DATA_W +: DATA_W];
                    id_q <= gnt_idx;
                end
                M1: k1 <= prod;
                M2: k2 <= prod;
                M3: begin
                    out_real <= k1 - prod;
                    out_imag <= k1 + k2;
                    out_id   <= id_q;
                end
                default: ;
            endcase
        end
    end

`ifndef CMUL_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves past the winner only when a request is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (state == IDLE && gnt_any)
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
`endif

endmodule
